// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: instruction-memory and decoder handshake bundle for the fetch stage
interface instr_fetch_unit_if #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 16
);
  logic                   imem_req;
  logic [PC_WIDTH-1:0]    imem_addr;
  logic                   imem_ack;
  logic [INSTR_WIDTH-1:0] imem_rdata;
  logic                   instr_valid;
  logic [INSTR_WIDTH-1:0] instruction;
  logic [PC_WIDTH-1:0]    instr_pc;
  logic                   instr_ready;
  logic                   jmp;
  logic [7:0]             jmp_addr;
  logic                   br_taken;
  logic [5:0]             br_imm;
  modport master (
    output imem_req, imem_addr, instr_valid, instruction, instr_pc,
    input  imem_ack, imem_rdata, instr_ready, jmp, jmp_addr, br_taken, br_imm
  );
  modport slave (
    input  imem_req, imem_addr, instr_valid, instruction, instr_pc,
    output imem_ack, imem_rdata, instr_ready, jmp, jmp_addr, br_taken, br_imm
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC, req/ack fetch, word buffer, jump/branch redirect; FETCH_PREFETCH_EN selects a 2-entry buffer
module instr_fetch_unit #(
  parameter int                  PC_WIDTH    = 8,
  parameter int                  INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input logic                 clk,
  input logic                 rst,
  instr_fetch_unit_if.master  f
);
`ifdef FETCH_PREFETCH_EN
  localparam logic [1:0] DEPTH = 2'd2;
`else
  localparam logic [1:0] DEPTH = 2'd1;
`endif
  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;
  typedef struct packed {
    logic [INSTR_WIDTH-1:0] data;
    logic [PC_WIDTH-1:0]    pc;
  } entry_t;
  state_t              state, state_n;
  entry_t              mem [2];
  logic [1:0]          cnt, cnt_pop;
  logic [PC_WIDTH-1:0] fetch_pc, fetch_pc_n, addr, target;
  logic                accept, redir, busy, push;
  assign f.instr_valid = cnt != 2'd0;
  assign f.instruction = mem[0].data;
  assign f.instr_pc    = mem[0].pc;
  assign f.imem_req    = busy;
  assign f.imem_addr   = addr;
  assign busy    = state != IDLE;
  assign accept  = f.instr_valid & f.instr_ready;
  assign redir   = accept & (f.jmp | f.br_taken);
  assign push    = state == REQ & f.imem_ack & ~redir;
  assign cnt_pop = cnt - {1'b0, accept};
  assign target  = f.jmp ? PC_WIDTH'(f.jmp_addr)
                         : f.instr_pc + PC_WIDTH'(1) + PC_WIDTH'(signed'(f.br_imm));
  // A slot is always reserved before a request goes out, so an ack can always be stored
  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    if (redir) begin
      fetch_pc_n = target;
      state_n    = (busy && !f.imem_ack) ? DROP : REQ;
    end else if (state == IDLE) begin
      state_n = cnt_pop < DEPTH ? REQ : IDLE;
    end else if (f.imem_ack) begin
      state_n    = (state == DROP || cnt_pop + 2'd1 < DEPTH) ? REQ : IDLE;
      fetch_pc_n = state == REQ ? fetch_pc + PC_WIDTH'(1) : fetch_pc;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      addr     <= RESET_PC;
      cnt      <= 2'd0;
      mem      <= '{default: '0};
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      addr     <= state_n == DROP ? addr : fetch_pc_n;
      cnt      <= redir ? 2'd0 : cnt_pop + {1'b0, push};
      if (accept) mem[0] <= mem[1];
      if (push) mem[cnt_pop[0]] <= '{data: f.imem_rdata, pc: addr};
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: scoreboard bench; memory returns {~addr, addr}, monitor checks accepted words in order
module tb_instr_fetch_unit;
  logic clk = 0;
  logic rst = 0;
  always #5 clk = ~clk;

  instr_fetch_unit_if #(.PC_WIDTH(8), .INSTR_WIDTH(16)) fi ();
  instr_fetch_unit #(.PC_WIDTH(8), .INSTR_WIDTH(16), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .f(fi)
  );

  int tests = 0;
  int fails = 0;
  logic [7:0] expq [$];
  logic       ready_en = 0;
  logic       jmp_arm = 0, br_arm = 0;
  logic [7:0] jmp_pc = 0, jmp_tgt = 0, br_pc = 0, br_tgt = 0;
  logic [5:0] br_imm_v = 0;
  int         mem_lat = 0;
  logic       chk_redir = 0;
  logic [7:0] redir_exp = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory model: ack after mem_lat wait cycles, data derived from address
  initial begin
    int waited = 0;
    fi.imem_ack = 0;
    fi.imem_rdata = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst || fi.imem_ack) waited = 0;
      if (rst && fi.imem_req && waited >= mem_lat) fi.imem_ack = 1;
      else begin
        fi.imem_ack = 0;
        if (rst && fi.imem_req) waited++;
      end
      fi.imem_rdata = {~fi.imem_addr, fi.imem_addr};
    end
  end

  // Decoder model: flags jump/branch on the armed head address
  initial begin
    fi.instr_ready = 0; fi.jmp = 0; fi.jmp_addr = 0; fi.br_taken = 0; fi.br_imm = 0;
    forever begin
      @(posedge clk);
      #1;
      fi.instr_ready = ready_en;
      fi.jmp = jmp_arm && fi.instr_valid && fi.instr_pc == jmp_pc;
      fi.jmp_addr = jmp_tgt;
      fi.br_taken = br_arm && fi.instr_valid && fi.instr_pc == br_pc;
      fi.br_imm = br_imm_v;
    end
  end

  // Monitor: pops the scoreboard on every accepted word
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (chk_redir) begin
          chk_redir = 0;
          check("redir_req", 32'(fi.imem_req), 32'd1);
          check("redir_addr", 32'(fi.imem_addr), 32'(redir_exp));
          check("redir_flush", 32'(fi.instr_valid), 32'd0);
        end
        if (fi.instr_valid && fi.instr_ready) begin
          if (expq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_word: got pc %0h expected none", fi.instr_pc);
          end else begin
            e = expq.pop_front();
            check("pc", 32'(fi.instr_pc), 32'(e));
            check("data", 32'(fi.instruction), 32'({~e, e}));
          end
          if (fi.jmp || fi.br_taken) begin
            chk_redir = 1;
            // an unacked request is held (old address) while it drains
            redir_exp = (fi.imem_req && !fi.imem_ack) ? fi.imem_addr : (fi.jmp ? jmp_tgt : br_tgt);
            if (fi.jmp) jmp_arm = 0;
            if (fi.br_taken) br_arm = 0;
          end
        end
      end
    end
  end

  task automatic do_reset();
    ready_en = 0; jmp_arm = 0; br_arm = 0; mem_lat = 0;
    @(negedge clk);
    rst = 0;
    expq.delete();
    chk_redir = 0;
    #1;
    check("rst_req", 32'(fi.imem_req), 32'd0);
    check("rst_addr", 32'(fi.imem_addr), 32'h00);
    check("rst_valid", 32'(fi.instr_valid), 32'd0);
    check("rst_instr", 32'(fi.instruction), 32'h0);
    check("rst_pc", 32'(fi.instr_pc), 32'h0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst = 1;
    @(posedge clk);
    @(negedge clk);
    check("first_req", 32'(fi.imem_req), 32'd1);
    check("first_addr", 32'(fi.imem_addr), 32'h00);
    check("first_valid", 32'(fi.instr_valid), 32'd0);
    @(negedge clk);
    check("lat_valid", 32'(fi.instr_valid), 32'd1);
    check("lat_pc", 32'(fi.instr_pc), 32'h00);
    check("lat_data", 32'(fi.instruction), 32'hFF00);
  endtask

  task automatic wait_level(input int lvl, input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (expq.size() <= lvl) begin ok = 1; break; end
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL timeout: got %0d words pending expected %0d", expq.size(), lvl);
    end
  endtask

  task automatic push_range(input logic [7:0] a, input int n);
    for (int i = 0; i < n; i++) expq.push_back(a + 8'(i));
  endtask

  initial begin
    bit seen;
    // Sequential fetch then jump at 05 to 40
    do_reset();
    jmp_pc = 8'h05; jmp_tgt = 8'h40; jmp_arm = 1;
    push_range(8'h00, 6);
    push_range(8'h40, 5);
    ready_en = 1;
    wait_level(0, 300);
    // Stall: buffer fills, request drops, order preserved
    do_reset();
    repeat (8) @(negedge clk);
    check("stall0_req", 32'(fi.imem_req), 32'd0);
    check("stall0_valid", 32'(fi.instr_valid), 32'd1);
    check("stall0_pc", 32'(fi.instr_pc), 32'h00);
    push_range(8'h00, 12);
    ready_en = 1;
    wait_level(6, 200);
    ready_en = 0;
    repeat (6) @(negedge clk);
    check("stall_req", 32'(fi.imem_req), 32'd0);
    check("stall_valid", 32'(fi.instr_valid), 32'd1);
    check("stall_pc", 32'(fi.instr_pc), 32'(expq[0]));
    ready_en = 1;
    wait_level(0, 300);
    // Taken beq at 10, offset -4, slow memory
    do_reset();
    mem_lat = 3;
    br_pc = 8'h10; br_imm_v = 6'b111100; br_tgt = 8'h0D; br_arm = 1;
    push_range(8'h00, 17);
    push_range(8'h0D, 6);
    ready_en = 1;
    wait_level(0, 800);
    // PC wrap FF -> 00
    do_reset();
    jmp_pc = 8'h02; jmp_tgt = 8'hFD; jmp_arm = 1;
    push_range(8'h00, 3);
    push_range(8'hFD, 5);
    ready_en = 1;
    wait_level(0, 200);
    // Branch target wrap: FE + 1 + 5 = 04
    do_reset();
    jmp_pc = 8'h01; jmp_tgt = 8'hFC; jmp_arm = 1;
    br_pc = 8'hFE; br_imm_v = 6'd5; br_tgt = 8'h04; br_arm = 1;
    push_range(8'h00, 2);
    push_range(8'hFC, 3);
    push_range(8'h04, 2);
    ready_en = 1;
    wait_level(0, 200);
    // jmp wins over br_taken on the same word
    do_reset();
    jmp_pc = 8'h03; jmp_tgt = 8'h20; jmp_arm = 1;
    br_pc = 8'h03; br_imm_v = 6'd0; br_tgt = 8'h04; br_arm = 1;
    push_range(8'h00, 4);
    push_range(8'h20, 2);
    ready_en = 1;
    wait_level(0, 200);
    // Reset while a request waits for its ack
    do_reset();
    mem_lat = 5;
    expq.push_back(8'h00);
    ready_en = 1;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (fi.imem_req && !fi.imem_ack) begin seen = 1; break; end
    end
    check("pending_seen", 32'(seen), 32'd1);
    check("pending_drained", 32'(expq.size()), 32'd0);
    #2 rst = 0;
    #1;
    check("midrst_req", 32'(fi.imem_req), 32'd0);
    check("midrst_valid", 32'(fi.instr_valid), 32'd0);
    check("midrst_addr", 32'(fi.imem_addr), 32'h00);
    do_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
